// File: rtl/regfile_write_sequencer_pkg.sv
// Shared constants for the register-file write-back sequencer: register/mask
// encodings, FSM state codes and a small request-validity helper.
package regfile_write_sequencer_pkg;

  typedef logic [4:0] reg_addr_t;

  localparam reg_addr_t  REG_ZERO  = 5'd0;
  localparam logic [3:0] MASK_FULL = 4'b1111;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RD   = 2'd1;
  localparam logic [1:0] ST_WR   = 2'd2;

  // Writes to $zero are architecturally invisible, so they are discarded early.
  function automatic logic is_zero_reg(input reg_addr_t dst);
    return dst == REG_ZERO;
  endfunction

endpackage

// File: rtl/regfile_write_sequencer_if.sv
// Write-back request channel: valid/ready handshake carrying destination,
// lane-aligned data and byte-lane enables.
interface regfile_write_sequencer_if #(
  parameter int DATA_W = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic [4:0]            in_reg;
  logic [DATA_W-1:0]     in_data;
  logic [DATA_W/8-1:0]   in_mask;

  modport master (
    output in_valid, in_reg, in_data, in_mask,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_reg, in_data, in_mask,
    output in_ready
  );
endinterface

// File: rtl/regfile_write_sequencer_wb_req_fifo.sv
// Small circular request buffer with registered count and full/empty flags;
// the head entry is visible combinationally so the FSM can pop and act in one cycle.
module regfile_write_sequencer_wb_req_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 41
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W:0]   count_reg;
  logic             full_reg;
  logic             empty_reg;
  logic             push_ok;
  logic             pop_ok;

  assign push_ok   = push && !full_reg;
  assign pop_ok    = pop && !empty_reg;
  assign head_data = mem_reg[rd_ptr_reg];
  assign full      = full_reg;
  assign empty     = empty_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      full_reg   <= 1'b0;
      empty_reg  <= 1'b1;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push_ok, pop_ok})
        2'b10: begin
          count_reg <= count_reg + 1'b1;
          full_reg  <= (count_reg == (PTR_W+1)'(DEPTH - 1));
          empty_reg <= 1'b0;
        end
        2'b01: begin
          count_reg <= count_reg - 1'b1;
          full_reg  <= 1'b0;
          empty_reg <= (count_reg == (PTR_W+1)'(1));
        end
        default: ;
      endcase
    end
  end

  // Storage carries no reset; entries are only observed once the count marks them valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem_reg[wr_ptr_reg] <= push_data;
  end

endmodule

// File: rtl/regfile_write_sequencer.sv
// Write-back sequencer in front of the register file's single write port:
// queues requests, turns partial-lane writes into read-modify-write, drops $zero writes.
module regfile_write_sequencer
  import regfile_write_sequencer_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  parameter int DATA_W     = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  regfile_write_sequencer_if.slave   req,
  output logic [4:0]                 rf_read_reg,
  input  logic [DATA_W-1:0]          rf_read_data,
  output logic [4:0]                 rf_write_reg,
  output logic [DATA_W-1:0]          rf_write_data,
  output logic                       rf_reg_write,
  output logic                       rf_byte_ops,
  output logic                       fwd_valid,
  output logic [4:0]                 fwd_reg,
  output logic [DATA_W-1:0]          fwd_data,
  output logic                       busy
);
  localparam int LANES = DATA_W / 8;
  localparam int REQ_W = 5 + DATA_W + LANES;

  logic [REQ_W-1:0]  head_word;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_pop;
  logic              load_head;
  reg_addr_t         head_dst;
  logic [DATA_W-1:0] head_data;
  logic [LANES-1:0]  head_mask;
  logic              head_drop;
  logic              head_full;
  logic [DATA_W-1:0] merged_data;

  logic [1:0]        state_reg,    state_next;
  reg_addr_t         cur_dst_reg,  cur_dst_next;
  logic [DATA_W-1:0] cur_data_reg, cur_data_next;
  logic [LANES-1:0]  cur_mask_reg, cur_mask_next;
  logic              wr_en_reg,    wr_en_next;
  reg_addr_t         wr_dst_reg,   wr_dst_next;
  logic [DATA_W-1:0] wr_data_reg,  wr_data_next;

  regfile_write_sequencer_wb_req_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (REQ_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (req.in_valid),
    .push_data ({req.in_reg, req.in_data, req.in_mask}),
    .pop       (fifo_pop),
    .head_data (head_word),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign req.in_ready = !fifo_full;

  assign head_dst  = head_word[REQ_W-1 -: 5];
  assign head_data = head_word[LANES +: DATA_W];
  assign head_mask = head_word[LANES-1:0];
  assign head_drop = is_zero_reg(head_dst) || (head_mask == '0);
  assign head_full = (head_mask == '1);

  // The commit cycle doubles as a head-load cycle so full words stream at 1/cycle.
  assign load_head = (state_reg == ST_IDLE) || (state_reg == ST_WR);
  assign fifo_pop  = load_head && !fifo_empty;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    assign merged_data[8*gi +: 8] = cur_mask_reg[gi] ? cur_data_reg[8*gi +: 8]
                                                     : rf_read_data[8*gi +: 8];
  end

  always_comb begin
    state_next    = state_reg;
    cur_dst_next  = cur_dst_reg;
    cur_data_next = cur_data_reg;
    cur_mask_next = cur_mask_reg;
    wr_en_next    = 1'b0;
    wr_dst_next   = wr_dst_reg;
    wr_data_next  = wr_data_reg;
    case (state_reg)
      ST_IDLE, ST_WR: begin
        if (!fifo_empty) begin
          cur_dst_next  = head_dst;
          cur_data_next = head_data;
          cur_mask_next = head_mask;
          if (head_drop) begin
            state_next = ST_IDLE;
          end else if (head_full) begin
            state_next   = ST_WR;
            wr_en_next   = 1'b1;
            wr_dst_next  = head_dst;
            wr_data_next = head_data;
          end else begin
            state_next = ST_RD;
          end
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_RD: begin
        cur_data_next = merged_data;
        state_next    = ST_WR;
        wr_en_next    = 1'b1;
        wr_dst_next   = cur_dst_reg;
        wr_data_next  = merged_data;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      cur_dst_reg  <= REG_ZERO;
      cur_data_reg <= '0;
      cur_mask_reg <= '0;
      wr_en_reg    <= 1'b0;
      wr_dst_reg   <= REG_ZERO;
      wr_data_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      cur_dst_reg  <= cur_dst_next;
      cur_data_reg <= cur_data_next;
      cur_mask_reg <= cur_mask_next;
      wr_en_reg    <= wr_en_next;
      wr_dst_reg   <= wr_dst_next;
      wr_data_reg  <= wr_data_next;
    end
  end

  assign rf_read_reg   = cur_dst_reg;
  assign rf_write_reg  = wr_dst_reg;
  assign rf_write_data = wr_data_reg;
  assign rf_reg_write  = wr_en_reg;
  assign rf_byte_ops   = 1'b0;
  assign fwd_valid     = wr_en_reg;
  assign fwd_reg       = wr_dst_reg;
  assign fwd_data      = wr_data_reg;
  assign busy          = !fifo_empty || (state_reg != ST_IDLE);

endmodule

// File: tb/tb_regfile_write_sequencer.sv
// Directed bench for the write-back sequencer with a behavioural register file
// and a commit monitor; one line per transaction.
module tb_regfile_write_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  rf_read_reg;
  logic [31:0] rf_read_data;
  logic [4:0]  rf_write_reg;
  logic [31:0] rf_write_data;
  logic        rf_reg_write;
  logic        rf_byte_ops;
  logic        fwd_valid;
  logic [4:0]  fwd_reg;
  logic [31:0] fwd_data;
  logic        busy;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct packed {
    logic [4:0]  r;
    logic [31:0] d;
    logic [31:0] c;
  } commit_t;

  commit_t commits[$];
  logic [31:0] rf_mem [32];

  regfile_write_sequencer_if #(.DATA_W(32)) bus ();

  regfile_write_sequencer #(
    .FIFO_DEPTH (2),
    .DATA_W     (32)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req           (bus),
    .rf_read_reg   (rf_read_reg),
    .rf_read_data  (rf_read_data),
    .rf_write_reg  (rf_write_reg),
    .rf_write_data (rf_write_data),
    .rf_reg_write  (rf_reg_write),
    .rf_byte_ops   (rf_byte_ops),
    .fwd_valid     (fwd_valid),
    .fwd_reg       (fwd_reg),
    .fwd_data      (fwd_data),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) rf_mem[i] <= '0;
    end else if (rf_reg_write) begin
      rf_mem[rf_write_reg] <= rf_write_data;
    end
  end
  assign rf_read_data = rf_mem[rf_read_reg];

  always @(negedge clk) begin
    if (!reset && rf_reg_write) begin
      commits.push_back('{r: rf_write_reg, d: rf_write_data, c: cyc});
      $display("commit cyc=%0d reg=%0d data=%08h fwd_valid=%0b", cyc, rf_write_reg, rf_write_data, fwd_valid);
    end
  end

  // Drive from a negedge; returns at the negedge after the accepting posedge.
  task automatic push(input logic [4:0] r, input logic [31:0] d, input logic [3:0] m,
                      output int waited);
    waited = 0;
    bus.in_valid = 1'b1;
    bus.in_reg   = r;
    bus.in_data  = d;
    bus.in_mask  = m;
    while (!bus.in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (waited >= 20) begin
      errors++;
      $display("FAIL push_timeout reg=%0d in_ready=%0b required=1", r, bus.in_ready);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    $display("push reg=%0d data=%08h mask=%04b waited=%0d", r, d, m, waited);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_reg   = '0;
    bus.in_data  = '0;
    bus.in_mask  = '0;
    idle(3);
    checks++;
    if ({rf_read_reg, rf_write_reg, rf_write_data, rf_reg_write, rf_byte_ops,
         fwd_valid, fwd_reg, fwd_data, busy} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got we=%0b wreg=%0d wdata=%08h rreg=%0d busy=%0b required all 0",
               rf_reg_write, rf_write_reg, rf_write_data, rf_read_reg, busy);
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready got=%0b required=1", bus.in_ready);
    end
    reset = 1'b0;
    idle(2);
    commits.delete();
  endtask

  task automatic test_full_word;
    int w;
    push(5'd5, 32'hDEADBEEF, 4'b1111, w);
    checks++;
    if (rf_reg_write !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL full_t1 got we=%0b busy=%0b required we=0 busy=1", rf_reg_write, busy);
    end
    @(negedge clk);
    checks++;
    if (rf_reg_write !== 1'b1 || rf_write_reg !== 5'd5 || rf_write_data !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL full_t2_commit got we=%0b reg=%0d data=%08h required 1/5/DEADBEEF",
               rf_reg_write, rf_write_reg, rf_write_data);
    end
    checks++;
    if (fwd_valid !== 1'b1 || fwd_reg !== 5'd5 || fwd_data !== 32'hDEADBEEF || rf_byte_ops !== 1'b0) begin
      errors++;
      $display("FAIL full_fwd got v=%0b reg=%0d data=%08h bops=%0b required 1/5/DEADBEEF/0",
               fwd_valid, fwd_reg, fwd_data, rf_byte_ops);
    end
    @(negedge clk);
    checks++;
    if (rf_reg_write !== 1'b0 || fwd_valid !== 1'b0 || rf_write_data !== 32'hDEADBEEF || busy !== 1'b0) begin
      errors++;
      $display("FAIL full_hold got we=%0b fv=%0b data=%08h busy=%0b required 0/0/DEADBEEF/0",
               rf_reg_write, fwd_valid, rf_write_data, busy);
    end
    idle(2);
    commits.delete();
  endtask

  task automatic test_partial;
    int w;
    push(5'd7, 32'h11223344, 4'b1111, w);
    idle(3);
    commits.delete();
    push(5'd7, 32'hAABB0000, 4'b1100, w);
    checks++;
    if (rf_reg_write !== 1'b0) begin
      errors++;
      $display("FAIL partial_t1 got we=%0b required=0", rf_reg_write);
    end
    @(negedge clk);
    checks++;
    if (rf_read_reg !== 5'd7 || rf_reg_write !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL partial_rd got rreg=%0d we=%0b busy=%0b required 7/0/1", rf_read_reg, rf_reg_write, busy);
    end
    @(negedge clk);
    checks++;
    if (rf_reg_write !== 1'b1 || rf_write_reg !== 5'd7 || rf_write_data !== 32'hAABB3344) begin
      errors++;
      $display("FAIL partial_commit got we=%0b reg=%0d data=%08h required 1/7/AABB3344",
               rf_reg_write, rf_write_reg, rf_write_data);
    end
    idle(3);
    commits.delete();
  endtask

  task automatic test_drop;
    int w;
    push(5'd0, 32'hFFFFFFFF, 4'b1111, w);
    push(5'd3, 32'h00000001, 4'b0000, w);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL drop_busy_mid got=%0b required=1", busy);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL drop_busy_end got=%0b required=0", busy);
    end
    idle(3);
    checks++;
    if (commits.size() != 0) begin
      errors++;
      $display("FAIL drop_no_write got commits=%0d required=0", commits.size());
    end
    commits.delete();
  endtask

  task automatic test_back_to_back;
    int w;
    int ready_low = 0;
    for (int i = 1; i <= 4; i++) begin
      if (bus.in_ready !== 1'b1) ready_low++;
      push(5'(i), 32'h0000_0100 + 32'(i), 4'b1111, w);
    end
    idle(4);
    checks++;
    if (ready_low != 0) begin
      errors++;
      $display("FAIL b2b_in_ready got low_count=%0d required=0", ready_low);
    end
    checks++;
    if (commits.size() != 4) begin
      errors++;
      $display("FAIL b2b_count got=%0d required=4", commits.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (commits[i].r !== 5'(i + 1) || commits[i].d !== 32'h0000_0101 + 32'(i) ||
            commits[i].c !== commits[0].c + 32'(i)) begin
          errors++;
          $display("FAIL b2b_commit%0d got reg=%0d data=%08h cyc=%0d required reg=%0d data=%08h cyc=%0d",
                   i, commits[i].r, commits[i].d, commits[i].c, i + 1, 32'h101 + 32'(i), commits[0].c + 32'(i));
        end
      end
    end
    commits.delete();
  endtask

  task automatic test_stall;
    int w;
    logic [4:0]  exp_r [4];
    logic [31:0] exp_d [4];
    exp_r = '{5'd10, 5'd11, 5'd12, 5'd9};
    exp_d = '{32'h00005555, 32'hB0B0B0B0, 32'hC0C0C0C0, 32'h000000A9};
    push(5'd10, 32'h12345555, 4'b0011, w);
    push(5'd11, 32'hB0B0B0B0, 4'b1111, w);
    push(5'd12, 32'hC0C0C0C0, 4'b1111, w);
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL stall_full got in_ready=%0b required=0", bus.in_ready);
    end
    push(5'd9, 32'hFFFFFFA9, 4'b0001, w);
    checks++;
    if (w != 1) begin
      errors++;
      $display("FAIL stall_wait got waited=%0d required=1", w);
    end
    idle(6);
    checks++;
    if (commits.size() != 4) begin
      errors++;
      $display("FAIL stall_count got=%0d required=4", commits.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (commits[i].r !== exp_r[i] || commits[i].d !== exp_d[i]) begin
          errors++;
          $display("FAIL stall_commit%0d got reg=%0d data=%08h required reg=%0d data=%08h",
                   i, commits[i].r, commits[i].d, exp_r[i], exp_d[i]);
        end
      end
    end
    commits.delete();
  endtask

  task automatic test_reset_mid;
    int w;
    push(5'd7, 32'h000000EE, 4'b0001, w);
    push(5'd8, 32'h88888888, 4'b1111, w);
    checks++;
    if (rf_read_reg !== 5'd7 || busy !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_rd got rreg=%0d busy=%0b required 7/1", rf_read_reg, busy);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || bus.in_ready !== 1'b1 || rf_reg_write !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_after got busy=%0b in_ready=%0b we=%0b required 0/1/0",
               busy, bus.in_ready, rf_reg_write);
    end
    idle(4);
    checks++;
    if (commits.size() != 0) begin
      errors++;
      $display("FAIL rstmid_no_write got commits=%0d required=0", commits.size());
    end
  endtask

  initial begin
    reset = 1'b1;
    @(negedge clk);
    test_reset();
    test_full_word();
    test_partial();
    test_drop();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
